// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode's 16-bit inst input.
// Holds the PC and keeps at most one instruction-memory read outstanding.
// Returned words go into a small show-ahead FIFO that decode drains over a
// valid/ready handshake. A redirect flushes the FIFO and drops any read
// still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters for
// FIFO pushes (perf_fetched) and for cycles without a valid instruction
// (perf_stall).
module fetch_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            ck,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            dec_ready,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     perf_fetched,
  output logic [15:0]     perf_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // ISSUE: free to request; WAIT: response pending and wanted;
  // DROP: response pending but made stale by a redirect.
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] req_addr_reg;

  logic [15:0]     data_mem [DEPTH];
  logic [PC_W-1:0] addr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;

  logic issue_ok;
  logic push;
  logic pop;
  logic fifo_empty;

  // The space check runs only from ISSUE, where nothing is outstanding, so
  // a granted request always has a free slot waiting for its response.
  assign issue_ok   = rst_n && (state_reg == ISSUE) && (count_reg < FULL_CNT) && !redir_valid;
  assign push       = (state_reg == WAIT) && imem_rvalid && !redir_valid;
  assign fifo_empty = (count_reg == '0);
  assign inst_valid = !fifo_empty && !redir_valid;
  assign pop        = inst_valid && dec_ready;

  // State register.
  always_ff @(posedge ck) begin
    if (!rst_n) state_reg <= ISSUE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a redirect never leaves a pending response unaccounted for.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ISSUE: begin
        if (issue_ok) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)      state_next = ISSUE;
        else if (redir_valid) state_next = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_next = ISSUE;
      end
      default: state_next = ISSUE;
    endcase
  end

  // Memory request outputs; the address tracks the PC at all times.
  always_comb begin
    imem_req  = issue_ok;
    imem_addr = pc_reg;
  end

  // PC advance, redirect load, and capture of the address being fetched.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
    end else if (redir_valid) begin
      pc_reg <= redir_pc;
    end else if (issue_ok) begin
      req_addr_reg <= pc_reg;
      pc_reg       <= pc_reg + PC_W'(1);
    end
  end

  // FIFO storage; no reset needed since reads are masked while empty.
  always_ff @(posedge ck) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      addr_mem[wr_ptr_reg] <= req_addr_reg;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge ck) begin
    if (!rst_n || redir_valid) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head of the FIFO, forced to zero when nothing is queued.
  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (!fifo_empty) begin
      inst    = data_mem[rd_ptr_reg];
      inst_pc = addr_mem[rd_ptr_reg];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != 16'hFFFF)) perf_fetched <= perf_fetched + 16'd1;
      if (!inst_valid && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
